// File: rtl/key_input_debounce.sv
// key_input_debounce: keypad front end. Each key is synchronised, sub-tick presses
// are stretched until the next clk_ce tick, and the level is debounced over
// DEBOUNCE_LEN consecutive ticks. Keys 0..7 are readable (active low) at REG_ADDR;
// every key raises a one-clk IRQ pulse when a press is accepted.
// Optional macro KEY_RELEASE_IRQ_EN: IRQ also pulses on accepted releases.

// Per-key lane: sync, stretch latch, debounce counter, IRQ pulse.
module key_input_debounce_lane #(
    parameter int DEBOUNCE_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_ce,
    input  logic key_raw,
    output logic stable,
    output logic irq
);
    localparam int CW = $clog2(DEBOUNCE_LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LEN - 1);

    logic [1:0]    r_sync;
    logic          r_latch;
    logic          r_stable;
    logic          r_irq;
    logic [CW-1:0] r_cnt;
    logic          w_sync;
    logic          w_sample;
    logic          w_accept;

    assign w_sync   = r_sync[1];
    // A press seen anywhere since the last tick counts as pressed for this tick.
    assign w_sample = r_latch | w_sync;
    assign w_accept = clk_ce && (w_sample != r_stable) && (r_cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous key level.
    always_ff @(posedge clk) begin
        if (reset) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], key_raw};
    end

    // Stretch latch: holds any press between ticks, cleared on each tick.
    always_ff @(posedge clk) begin
        if (reset)       r_latch <= 1'b0;
        else if (clk_ce) r_latch <= 1'b0;
        else if (w_sync) r_latch <= 1'b1;
    end

    // Debounce: a differing sample must persist DEBOUNCE_LEN ticks in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (clk_ce) begin
            if (w_sample == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= w_sample;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // IRQ pulse: registered, high for the single clk after an accepted event.
    always_ff @(posedge clk) begin
        if (reset) r_irq <= 1'b0;
`ifdef KEY_RELEASE_IRQ_EN
        else       r_irq <= w_accept;
`else
        else       r_irq <= w_accept && w_sample;
`endif
    end

    assign stable = r_stable;
    assign irq    = r_irq;
endmodule

// Top: array of lanes plus the combinational bus read port.
module key_input_debounce #(
    parameter int          NUM_KEYS     = 9,
    parameter int          DEBOUNCE_LEN = 4,
    parameter logic [23:0] REG_ADDR     = 24'h2052
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_ce,
    input  logic [NUM_KEYS-1:0] keys_active,
    input  logic [23:0]         bus_address_in,
    output logic [7:0]          bus_data_out,
    output logic [NUM_KEYS-1:0] key_irq,
    output logic [NUM_KEYS-1:0] keys_stable
);
    localparam int REG_KEYS = (NUM_KEYS < 8) ? NUM_KEYS : 8;

    logic [7:0] w_reg;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        key_input_debounce_lane #(
            .DEBOUNCE_LEN(DEBOUNCE_LEN)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clk_ce (clk_ce),
            .key_raw(keys_active[g]),
            .stable (keys_stable[g]),
            .irq    (key_irq[g])
        );
    end

    // Register bits are active low; reset forces all-released so it reads FF.
    for (genvar b = 0; b < 8; b++) begin : g_bit
        if (b < REG_KEYS) begin : g_used
            assign w_reg[b] = reset | ~keys_stable[b];
        end else begin : g_unused
            assign w_reg[b] = 1'b1;
        end
    end

    assign bus_data_out = (bus_address_in == REG_ADDR) ? w_reg : 8'h00;
endmodule

// File: tb/tb_key_input_debounce.sv
// Bench for key_input_debounce: two instances (DEBOUNCE_LEN 4 and 1) compared
// every cycle against a tick-level behavioural model, plus literal scenario checks.
module tb_key_input_debounce;
    localparam int NK = 9;

    logic        clk;
    logic        reset;
    logic        clk_ce;
    logic [23:0] addr;
    logic [NK-1:0] keys_a, keys_b;
    logic [NK-1:0] stab_a, stab_b, irq_a, irq_b;
    logic [7:0]  bus_a, bus_b;

    int n_chk = 0;
    int n_err = 0;
    int ph = 0;
    bit ce_rand = 0;
    bit chk_en = 0;
    int pc_a[NK];
    int pc_b[NK];

    key_input_debounce #(.NUM_KEYS(NK), .DEBOUNCE_LEN(4), .REG_ADDR(24'h2052)) u_dut_a (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .keys_active(keys_a),
        .bus_address_in(addr), .bus_data_out(bus_a), .key_irq(irq_a), .keys_stable(stab_a));

    key_input_debounce #(.NUM_KEYS(NK), .DEBOUNCE_LEN(1), .REG_ADDR(24'h2052)) u_dut_b (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .keys_active(keys_b),
        .bus_address_in(addr), .bus_data_out(bus_b), .key_irq(irq_b), .keys_stable(stab_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw levels reach the logic two clocks later; every tick sees "pressed at
    // any point since the previous tick"; a key flips once LEN ticks in a row
    // disagree with its accepted level.
    logic [NK-1:0] m_stable[2];
    logic [NK-1:0] m_irq[2];
    logic [NK-1:0] m_seen[2];
    logic [NK-1:0] m_h1[2];
    logic [NK-1:0] m_h2[2];
    int            m_run[2][NK];

    function automatic int lenof(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    always @(posedge clk) begin
        logic [NK-1:0] raw, sync, smp;
        for (int u = 0; u < 2; u++) begin
            raw = (u == 0) ? keys_a : keys_b;
            if (reset) begin
                m_stable[u] = '0; m_irq[u] = '0; m_seen[u] = '0;
                m_h1[u] = '0; m_h2[u] = '0;
                for (int k = 0; k < NK; k++) m_run[u][k] = 0;
            end else begin
                sync = m_h2[u];
                m_irq[u] = '0;
                if (clk_ce) begin
                    smp = m_seen[u] | sync;
                    m_seen[u] = '0;
                    for (int k = 0; k < NK; k++) begin
                        if (smp[k] == m_stable[u][k]) m_run[u][k] = 0;
                        else begin
                            m_run[u][k]++;
                            if (m_run[u][k] >= lenof(u)) begin
                                m_stable[u][k] = smp[k];
                                m_run[u][k] = 0;
`ifdef KEY_RELEASE_IRQ_EN
                                m_irq[u][k] = 1'b1;
`else
                                m_irq[u][k] = smp[k];
`endif
                            end
                        end
                    end
                end else begin
                    m_seen[u] = m_seen[u] | sync;
                end
                m_h2[u] = m_h1[u];
                m_h1[u] = raw;
            end
        end
    end

    function automatic logic [7:0] exp_bus(input int u);
        if (addr != 24'h2052) return 8'h00;
        if (reset) return 8'hFF;
        return ~m_stable[u][7:0];
    endfunction

    // Every-cycle compare, away from the active edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("stable_a", 32'(stab_a), 32'(m_stable[0]));
            chk("irq_a",    32'(irq_a),  32'(m_irq[0]));
            chk("bus_a",    32'(bus_a),  32'(exp_bus(0)));
            chk("stable_b", 32'(stab_b), 32'(m_stable[1]));
            chk("irq_b",    32'(irq_b),  32'(m_irq[1]));
            chk("bus_b",    32'(bus_b),  32'(exp_bus(1)));
            for (int k = 0; k < NK; k++) begin
                if (irq_a[k] === 1'b1) pc_a[k]++;
                if (irq_b[k] === 1'b1) pc_b[k]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // The edge following a step that leaves ph = k carries a tick iff k%4 == 0.
    task automatic step();
        @(negedge clk);
        ph++;
        if (ce_rand) clk_ce = ($urandom_range(0, 2) == 0);
        else         clk_ce = (ph % 4 == 0);
    endtask

    // After align, a key change reaches the synchroniser output on the first
    // clock after a tick, so held levels line up exactly with tick intervals.
    task automatic align();
        while (ph % 4 != 3) step();
    endtask

    initial begin
        reset = 1'b1; clk_ce = 1'b0; addr = 24'h2052;
        keys_a = '0; keys_b = '0;
        for (int k = 0; k < NK; k++) begin pc_a[k] = 0; pc_b[k] = 0; end
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) step();
        chk("rst_bus", 32'(bus_a), 32'h0FF);
        chk("rst_irq", 32'(irq_a), 32'h0);
        chk("rst_stable", 32'(stab_a), 32'h0);
        reset = 1'b0;

        // Hold key 2: accepted on the 4th tick, one IRQ pulse only.
        align();
        keys_a[2] = 1'b1;
        repeat (17) step();
        chk("k2_pre", 32'(stab_a[2]), 32'h0);
        step();
        chk("k2_bus", 32'(bus_a), 32'h0FB);
        chk("k2_irq", 32'(irq_a), 32'h004);
        step();
        chk("k2_irq_drop", 32'(irq_a), 32'h000);
        repeat (40) step();
        chk("k2_once", 32'(pc_a[2]), 32'd1);

        // Release key 2.
        keys_a[2] = 1'b0;
        repeat (40) step();
        chk("k2_rel_bus", 32'(bus_a), 32'h0FF);
`ifdef KEY_RELEASE_IRQ_EN
        chk("k2_rel_irq", 32'(pc_a[2]), 32'd2);
`else
        chk("k2_rel_irq", 32'(pc_a[2]), 32'd1);
`endif

        // Bounce key 0: 2 ticks pressed, 1 tick released, 5 times.
        align();
        repeat (5) begin
            keys_a[0] = 1'b1; repeat (8) step();
            keys_a[0] = 1'b0; repeat (4) step();
        end
        repeat (20) step();
        chk("bounce_bus", 32'(bus_a), 32'h0FF);
        chk("bounce_irq", 32'(pc_a[0]), 32'd0);

        // Key 8 is IRQ-only; wrong address reads zero.
        keys_a[8] = 1'b1;
        repeat (25) step();
        chk("k8_irq", 32'(pc_a[8]), 32'd1);
        chk("k8_stable", 32'(stab_a[8]), 32'h1);
        chk("k8_bus", 32'(bus_a), 32'h0FF);
        addr = 24'h2051;
        #1;
        chk("addr_miss_a", 32'(bus_a), 32'h000);
        chk("addr_miss_b", 32'(bus_b), 32'h000);
        addr = 24'h2052;
        keys_a[8] = 1'b0;
        repeat (25) step();

        // Reset part way through key 1 debounce.
        align();
        keys_a[1] = 1'b1;
        repeat (14) step();
        reset = 1'b1;
        repeat (3) step();
        keys_a[1] = 1'b0;
        reset = 1'b0;
        repeat (3) step();
        chk("k1_rst_irq", 32'(pc_a[1]), 32'd0);
        chk("k1_rst_stable", 32'(stab_a[1]), 32'h0);
        repeat (10) step();
        align();
        keys_a[1] = 1'b1;
        repeat (17) step();
        chk("k1_re_3ticks", 32'(stab_a[1]), 32'h0);
        step();
        chk("k1_re_4ticks", 32'(stab_a[1]), 32'h1);
        chk("k1_re_irq", 32'(pc_a[1]), 32'd1);
        keys_a[1] = 1'b0;
        repeat (30) step();

        // DEBOUNCE_LEN = 1: one-clk blip on key 5 between ticks is caught.
        align();
        step(); step();
        keys_b[5] = 1'b1;
        step();
        keys_b[5] = 1'b0;
        repeat (2) step();
        chk("b5_pre_bus", 32'(bus_b), 32'h0FF);
        step();
        chk("b5_bus", 32'(bus_b), 32'h0DF);
        chk("b5_irq", 32'(irq_b), 32'h020);
        repeat (4) step();
        chk("b5_rel_bus", 32'(bus_b), 32'h0FF);
        chk("b5_irq_cnt", 32'(pc_b[5]), 32'd1);

        // Randomised phase: irregular ticks, sparse key toggles, address mix, rare resets.
        ce_rand = 1'b1;
        repeat (4000) begin
            step();
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 15) == 0) keys_a[k] = ~keys_a[k];
                if ($urandom_range(0, 15) == 0) keys_b[k] = ~keys_b[k];
            end
            case ($urandom_range(0, 7))
                0:       addr = 24'h2051;
                1:       addr = 24'($urandom);
                default: addr = 24'h2052;
            endcase
            reset = ($urandom_range(0, 499) == 0);
        end
        ce_rand = 1'b0;
        reset = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
